alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer for the 1-bit ALU slice. Given WIDTH-bit operands, it drives the slice one bit per clock, LSB first.
- Feeds the slice's carry-out back as the next bit's carry-in.
- Collects the result, final carry and N (last-bit) flag.
- Sits between a requester (start/done handshake) and one external ALU_1_bit instance. This gives the 4-bit ALU function with one slice instead of four.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.
- CW, $clog2(WIDTH), bit-index counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  mode; latched on accept, driven as {alu_m1, alu_m0}
- a_in  input  WIDTH  operand A; latched on accept
- b_in  input  WIDTH  operand B; latched on accept
- cin_in  input  1  carry-in for bit 0; latched on accept
- alu_a  output  1  A bit to slice
- alu_b  output  1  B bit to slice
- alu_cin  output  1  carry to slice
- alu_m0  output  1  mode bit 0 to slice
- alu_m1  output  1  mode bit 1 to slice
- alu_f  input  1  slice result bit
- alu_cout  input  1  slice carry-out
- alu_n  input  1  slice N output
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- result  output  WIDTH  assembled result
- cout  output  1  carry-out of MSB slice operation
- n_flag  output  1  alu_n captured on MSB bit
- zero  output  1  result == 0, registered with result

Behaviour:
- Single clock. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - state goes to IDLE; bit index and internal shift/carry registers clear to 0.
  - result, cout, n_flag, zero, busy and done all become 0.
  - rst overrides start in the same cycle.
- Reset values on the ALU side: alu_a, alu_b, alu_cin, alu_m0 and alu_m1 are all 0.
- IDLE:
  - busy=0, done=0. All alu_* outputs are 0.
  - result, cout, n_flag and zero hold their last values.
  - start=1 at an edge means accept: latch a_in, b_in, op and cin_in; clear the bit index; go to RUN.
- RUN lasts exactly WIDTH cycles; bit index i runs 0..WIDTH-1.
  - busy=1.
  - Slice inputs are combinational from registered state: alu_a=A_reg[i] and alu_b=B_reg[i].
  - alu_cin = latched cin for i=0, otherwise the carry register. {alu_m1, alu_m0} = latched op, held for the whole operation.
  - Each edge: capture alu_f into result bit i (working register), capture alu_cout into the carry register, then i++.
  - At the edge where i=WIDTH-1:
    - result takes the full working value;
    - cout takes alu_cout;
    - n_flag takes alu_n;
    - zero is computed from the final value;
    - state goes to DONE.
  - start is ignored in RUN. The new operand and op values presented then are not latched.
  - Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from accept.
- DONE, one cycle:
  - done=1, busy=0; alu_* outputs are 0.
  - result, cout, n_flag and zero are valid. They hold until the next accepted operation completes; they do not change during RUN.
  - start=1 at this edge is accepted: back-to-back operation, straight to RUN, no IDLE cycle. Otherwise go to IDLE.
- Width rules:
  - The carry register is 1 bit.
  - The bit index counts 0..WIDTH-1 and never wraps inside an operation.
  - Any carry out of bit WIDTH-1 is reported on cout only; it is never fed into a new operation.
- op is a pure pass-through. The controller assigns no meaning to the mode encoding.
- Undriven/X alu_f from the slice during RUN propagates to result; no masking.

Test Plan:
For all scenarios except 5, the bench ties the slice ports to a full-adder model (f=a^b^cin, cout=maj(a,b,cin), n=f) with WIDTH=4.
1. Reset, then start with a_in=4'h3, b_in=4'h5, cin_in=0, op=2'b01 -> busy for exactly 4 cycles, then done pulse. result=4'h8, cout=0, n_flag=1, zero=0, and {alu_m1,alu_m0}=2'b01 throughout RUN.
2. a_in=4'hF, b_in=4'h1, cin_in=0 -> result=4'h0, cout=1, zero=1, n_flag=0. alu_cin sequence observed over RUN is 0,1,1,1.
3. a_in=4'h7, b_in=4'h0, cin_in=1 -> result=4'h8, cout=0, and alu_cin is 1 on bit 0. Then drive start=1 again during RUN with different operands -> that request is ignored; result still 4'h8.
4. start held high through DONE with a_in=4'h2, b_in=4'h2 queued -> second operation begins the cycle after done with no IDLE gap. result 4'h4 appears at the second done, and the first result is held during the second RUN.
5. Assert rst at RUN bit index 2 -> next cycle: IDLE, busy=0, done=0, result=0, cout=0, all alu_* outputs 0. A following start completes normally.
6. Sweep all 256 {a_in, b_in} pairs with cin_in in {0,1}, against a reference model with result=(a+b+cin)[3:0] and cout=bit 4 -> zero mismatches. done pulses are exactly WIDTH+1 cycles apart from each accept.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer for a single external 1-bit ALU slice.
// Operands are walked LSB first, one bit per clock. The slice carry-out is
// fed back as the next bit's carry-in. The result, final carry, N flag and
// zero flag are collected and held until the next operation completes.
module alu_serial_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_m0,
  output logic             alu_m1,
  input  logic             alu_f,
  input  logic             alu_cout,
  input  logic             alu_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             n_flag,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic             cin_r;
  logic             carry_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] work_next_s;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             n_flag_r;
  logic             zero_r;
  logic             accept_s;
  logic             last_s;

  // Accept only when idle or finishing; mark the final bit of a RUN.
  always_comb begin
    accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    last_s   = (state_r == RUN) && (idx_r == LAST_IDX);
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Working value with the current slice result merged into bit idx_r.
  always_comb begin
    work_next_s        = work_r;
    work_next_s[idx_r] = alu_f;
  end

  // Operand latching, per-bit capture and final result/flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 2'b00;
      cin_r    <= 1'b0;
      carry_r  <= 1'b0;
      work_r   <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      n_flag_r <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept_s) begin
      idx_r   <= '0;
      a_r     <= a_in;
      b_r     <= b_in;
      op_r    <= op;
      cin_r   <= cin_in;
      carry_r <= 1'b0;
      work_r  <= '0;
    end else if (state_r == RUN) begin
      work_r  <= work_next_s;
      carry_r <= alu_cout;
      if (last_s) begin
        idx_r    <= '0;
        result_r <= work_next_s;
        cout_r   <= alu_cout;
        n_flag_r <= alu_n;
        zero_r   <= (work_next_s == '0);
      end else begin
        idx_r <= idx_r + CW'(1);
      end
    end
  end

  // Slice drive: bit idx_r of the latched operands during RUN, quiet otherwise.
  always_comb begin
    alu_a   = 1'b0;
    alu_b   = 1'b0;
    alu_cin = 1'b0;
    alu_m0  = 1'b0;
    alu_m1  = 1'b0;
    if (state_r == RUN) begin
      alu_a   = a_r[idx_r];
      alu_b   = b_r[idx_r];
      alu_cin = (idx_r == '0) ? cin_r : carry_r;
      alu_m0  = op_r[0];
      alu_m1  = op_r[1];
    end else begin
      alu_a   = 1'b0;
      alu_b   = 1'b0;
      alu_cin = 1'b0;
      alu_m0  = 1'b0;
      alu_m1  = 1'b0;
    end
  end

  assign busy   = (state_r == RUN);
  assign done   = (state_r == DONE);
  assign result = result_r;
  assign cout   = cout_r;
  assign n_flag = n_flag_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a full-adder slice model.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             alu_a, alu_b, alu_cin, alu_m0, alu_m1;
  logic             alu_f, alu_cout, alu_n;
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic             cout, n_flag, zero;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_res  = 4'h0;
  logic       exp_cout = 1'b0;
  logic       exp_n    = 1'b0;
  logic       exp_zero = 1'b0;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_m0(alu_m0), .alu_m1(alu_m1),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_n(alu_n),
    .busy(busy), .done(done), .result(result),
    .cout(cout), .n_flag(n_flag), .zero(zero)
  );

  always #5 clk = ~clk;

  // Full-adder slice model.
  assign alu_f    = alu_a ^ alu_b ^ alu_cin;
  assign alu_cout = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
  assign alu_n    = alu_f;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle after DONE: quiet outputs, results held.
  task automatic idle_cycle();
    step();
    check_val("idle_ctl", {busy, done, alu_a, alu_b, alu_cin, alu_m1, alu_m0}, 32'd0);
    check_val("idle_hold", {result, cout, n_flag, zero}, {exp_res, exp_cout, exp_n, exp_zero});
  endtask

  // Issue one operation (called in IDLE or DONE) and check it through to DONE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [1:0] m, input bit poke);
    int         sum;
    logic [3:0] carries;
    sum     = int'(a) + int'(b) + int'(c);
    carries = 4'(sum ^ int'(a) ^ int'(b));
    start  = 1'b1; a_in = a; b_in = b; cin_in = c; op = m;
    step();
    start = 1'b0;
    a_in  = 4'($urandom);
    b_in  = 4'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      check_val("run_ctl", {busy, done, alu_m1, alu_m0},
                {1'b1, 1'b0, m});
      check_val("run_bits", {alu_a, alu_b, alu_cin}, {a[i], b[i], carries[i]});
      check_val("run_hold", {result, cout, n_flag, zero}, {exp_res, exp_cout, exp_n, exp_zero});
      if (poke && i == 1) begin
        start = 1'b1; a_in = 4'h9; b_in = 4'h9; cin_in = ~c; op = ~m;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start    = 1'b0;
    exp_res  = 4'(sum);
    exp_cout = sum[4];
    exp_n    = exp_res[3];
    exp_zero = (exp_res == 4'h0);
    check_val("done_ctl", {busy, done, alu_a, alu_b, alu_cin, alu_m1, alu_m0}, 32'h20);
    check_val("done_res", {28'd0, result}, {28'd0, exp_res});
    check_val("done_flags", {cout, n_flag, zero}, {exp_cout, exp_n, exp_zero});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a_in = 4'h0; b_in = 4'h0; cin_in = 1'b0;
    step();
    start = 1'b1;
    step();
    check_val("reset_state",
              {busy, done, result, cout, n_flag, zero, alu_a, alu_b, alu_cin, alu_m1, alu_m0},
              32'd0);
    start = 1'b0;
    rst   = 1'b0;
    idle_cycle();

    // Directed cases.
    run_op(4'h3, 4'h5, 1'b0, 2'b01, 1'b0);
    idle_cycle();
    run_op(4'hF, 4'h1, 1'b0, 2'b10, 1'b0);
    idle_cycle();
    run_op(4'h7, 4'h0, 1'b1, 2'b11, 1'b1);
    idle_cycle();
    run_op(4'h7, 4'h0, 1'b1, 2'b00, 1'b0);
    run_op(4'h2, 4'h2, 1'b0, 2'b01, 1'b0);
    idle_cycle();

    // Reset in the middle of RUN at bit index 2.
    start = 1'b1; a_in = 4'hA; b_in = 4'h6; cin_in = 1'b1; op = 2'b11;
    step();
    start = 1'b0;
    step();
    step();
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst",
              {busy, done, result, cout, n_flag, zero, alu_a, alu_b, alu_cin, alu_m1, alu_m0},
              32'd0);
    exp_res = 4'h0; exp_cout = 1'b0; exp_n = 1'b0; exp_zero = 1'b0;
    idle_cycle();
    run_op(4'hA, 4'h6, 1'b1, 2'b10, 1'b0);
    idle_cycle();

    // Full operand sweep with random mode, carry order and random back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(4'(a), 4'(b), 1'(c), 2'($urandom_range(0, 3)), 1'b0);
          if ($urandom_range(0, 1) == 1) idle_cycle();
        end
      end
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
